// File: rtl/mul_add_arbiter.sv
// Round-robin front end for a shared multiply-add unit. Each requester gets
// at most one operation outstanding; its result is parked in a per-requester
// response register until the requester takes it.
module mul_add_arbiter #(
   parameter int N_REQ   = 4,
   parameter int LATENCY = 2
) (
   input  logic                 CLK,
   input  logic                 resetn,
   input  logic                 en,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [8*N_REQ-1:0]   req_a,
   input  logic [8*N_REQ-1:0]   req_b,
   input  logic [7*N_REQ-1:0]   req_c,
   input  logic [N_REQ-1:0]     req_signed,
   output logic [7:0]           mac_a,
   output logic [7:0]           mac_b,
   output logic [6:0]           mac_c,
   output logic                 mac_signed,
   output logic                 mac_valid,
   input  logic [19:0]          mac_result,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [20*N_REQ-1:0]  rsp_data,
   input  logic [N_REQ-1:0]     rsp_ready
);

   localparam int IW = $clog2(N_REQ);

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [6:0] c;
      logic       s;
   } op_t;

   logic [N_REQ-1:0][7:0]  a_arr, b_arr;
   logic [N_REQ-1:0][6:0]  c_arr;

   op_t                    op_q, op_d;
   logic [N_REQ-1:0]       busy_q, busy_d, elig, gnt, hs;
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d, gnt_idx;
   logic [IW:0]            cand;
   logic                   gnt_any;

   // vld_pipe_q[0] is the issue stage (drives mac_valid); stage LATENCY lines
   // up with mac_result from the unit.
   logic [LATENCY:0]           vld_pipe_q;
   logic [LATENCY:0][IW-1:0]   idx_pipe_q;

   logic [N_REQ-1:0]          rsp_valid_q, rsp_valid_d;
   logic [N_REQ-1:0][19:0]    rsp_data_q, rsp_data_d;

   assign a_arr = req_a;
   assign b_arr = req_b;
   assign c_arr = req_c;

   // busy is purely registered; reset also masks eligibility so req_ready is
   // low for the whole time resetn is asserted.
   assign elig = {N_REQ{en & resetn}} & req_valid & ~busy_q;
   assign hs   = rsp_valid_q & rsp_ready;

   // Round-robin search starting at rr_ptr_q; first eligible requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = {1'b0, rr_ptr_q} + (IW+1)'(off);
         if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
         if (!gnt_any && elig[cand[IW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[IW-1:0];
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   // Pointer advance, operand capture and busy tracking for the next edge.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      op_d     = op_q;
      if (gnt_any) begin
         rr_ptr_d = (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
         op_d     = '{a: a_arr[gnt_idx], b: b_arr[gnt_idx],
                      c: c_arr[gnt_idx], s: req_signed[gnt_idx]};
      end
      // grants only hit idle requesters and handshakes only busy ones
      busy_d = (busy_q | gnt) & ~hs;
   end

   // Result return: final tag stage steers mac_result into its requester slot.
   always_comb begin
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      rsp_data_d  = rsp_data_q;
      if (vld_pipe_q[LATENCY]) begin
         rsp_valid_d[idx_pipe_q[LATENCY]] = 1'b1;
         rsp_data_d[idx_pipe_q[LATENCY]]  = mac_result;
      end
   end

   // State registers; reset drops everything in flight.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         rr_ptr_q    <= '0;
         op_q        <= '0;
         busy_q      <= '0;
         vld_pipe_q  <= '0;
         idx_pipe_q  <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         op_q        <= op_d;
         busy_q      <= busy_d;
         vld_pipe_q  <= {vld_pipe_q[LATENCY-1:0], gnt_any};
         idx_pipe_q  <= {idx_pipe_q[LATENCY-1:0], gnt_idx};
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign req_ready  = gnt;
   assign mac_a      = op_q.a;
   assign mac_b      = op_q.b;
   assign mac_c      = op_q.c;
   assign mac_signed = op_q.s;
   assign mac_valid  = vld_pipe_q[0];
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;

endmodule

// File: doc/mul_add_arbiter.md
MUL_ADD_ARBITER -- requirements
Module: mul_add_arbiter

Interface
REQ-001 The block SHALL have one clock, CLK, and an asynchronous active-low reset, resetn; all state SHALL be clocked on the rising edge of CLK.
REQ-002 Parameter N_REQ SHALL default to 4 and give the number of requesters, range 2..8.
REQ-003 Parameter LATENCY SHALL default to 2 and give the cycles from mac_valid high to mac_result valid, range 1..4.
REQ-004 Ports SHALL be, as name / direction / width / meaning:
  CLK  in  1  clock
  resetn  in  1  asynchronous active-low reset
  en  in  1  grant enable; low blocks new grants
  req_valid  in  N_REQ  per-requester operation request
  req_ready  out  N_REQ  per-requester grant
  req_a  in  8*N_REQ  operand a, requester i at [8i+7:8i]
  req_b  in  8*N_REQ  operand b, requester i at [8i+7:8i]
  req_c  in  7*N_REQ  addend c, requester i at [7i+6:7i]
  req_signed  in  N_REQ  1 = a and b two's complement
  mac_a, mac_b  out  8 each  operands to the shared multiply-add unit
  mac_c  out  7  addend to the unit
  mac_signed  out  1  signedness to the unit
  mac_valid  out  1  operands valid this cycle
  mac_result  in  20  unit result, a*b+c
  rsp_valid  out  N_REQ  per-requester result held
  rsp_data  out  20*N_REQ  result for requester i at [20i+19:20i]
  rsp_ready  in  N_REQ  per-requester result consumed

Function
REQ-005 busy[i] SHALL be set from grant until the response handshake completes: either an operation is in flight for requester i, or rsp_valid[i] is high.
REQ-006 Requester i SHALL be eligible when en=1, req_valid[i]=1 and busy[i]=0; busy is registered state only.
REQ-007 At most one req_ready bit SHALL be high per cycle. It SHALL be combinational and go to the first eligible requester, searching round-robin from pointer rr_ptr.
REQ-008 On a grant to i, rr_ptr SHALL become (i+1) mod N_REQ at the edge; with no grant, rr_ptr SHALL hold.
REQ-009 At the grant edge, mac_a, mac_b, mac_c and mac_signed SHALL register requester i's operands, and mac_valid SHALL be 1 for exactly the following cycle; otherwise mac_valid=0 and the operand registers hold.
REQ-010 A tag pipeline of LATENCY stages (valid + requester index) SHALL track each issued operation; mac_result SHALL be sampled when the final stage is valid.
REQ-011 The sampled result SHALL load rsp_data[i] at that edge with rsp_valid[i]=1. Latency SHALL be exactly LATENCY+1 edges from the accept edge to the first cycle with rsp_valid high (3 for the default).
REQ-012 rsp_valid[i] and rsp_data[i] SHALL hold until an edge with rsp_ready[i]=1; rsp_valid[i] then clears.
REQ-013 A requester whose response handshakes in cycle k SHALL be grantable no earlier than cycle k+1.
REQ-014 en=0 SHALL block new grants only; in-flight operations complete and responses deliver normally.
REQ-015 The pipeline SHALL accept one new operation per cycle for distinct requesters, with no bubbles.
REQ-016 The block SHALL NOT alter data arithmetically; mac_result routes unchanged to rsp_data.

Reset
REQ-017 While resetn=0: req_ready=0, mac_valid=0, mac_a/mac_b/mac_c/mac_signed=0, rsp_valid=0, rsp_data=0, rr_ptr=0, all tag stages invalid, busy=0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight operations; no rsp_valid SHALL appear for them after reset release.

Verification
REQ-019 The bench SHALL model the multiply-add unit as a LATENCY-cycle pipe computing a*b+c, signed or unsigned per mac_signed, result 20 bits.
REQ-020 Single request: req 0, a=10, b=5, c=5, signed=0 -> rsp_data[0]=55 (0x00037) with rsp_valid[0] rising 3 edges after accept.
REQ-021 Unsigned and signed: req 1 with 255*255+0 unsigned -> 0x0FE01 (65025); req 2 with a=0x80, b=5, c=0 signed -> 0xFFD80 (-640); req 3 with a=0xFF, b=5 signed -> 0xFFFFB (-5).
REQ-022 Round-robin: all four req_valid held high, rsp_ready=1 -> grants 0,1,2,3 on consecutive cycles, mac_valid high for 4 consecutive cycles, then 0 again once busy[0] clears.
REQ-023 Backpressure: rsp_ready[0]=0 with req 0 still valid -> no second grant to 0, others still served; raise rsp_ready[0] -> req 0 re-granted no earlier than the next cycle.
REQ-024 en=0 with 2 operations in flight -> req_ready stays 0, both responses delivered; resetn pulsed low with 2 in flight -> all outputs 0 immediately, no response after release.
